mem_port_arbiter: RTL and testbench

Shares the processor's single-port instruction/data memory between three requesters: 0 = fetch sequencer, 1 = data unit (load/pop/push), 2 = program loader/debug.
- Round-robin arbitration, one access in flight at a time.
- Drives the memory's enable, write-enable, address and write-data lines.
- Returns read data with a per-requester done pulse.

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/mem_port_arbiter_rr_pick.sv | 27 ++
 rtl/mem_port_arbiter.sv | 155 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and constants for the memory port arbiter
package mem_arb_pkg;

    localparam int NREQ      = 3;
    localparam int REQ_FETCH = 0;
    localparam int REQ_DATA  = 1;
    localparam int REQ_LOAD  = 2;
    localparam int STAT_W    = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    function automatic logic [1:0] next_ptr(input logic [1:0] w);
        return (w == 2'(REQ_LOAD)) ? 2'(REQ_FETCH) : w + 2'd1;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// rtl/mem_port_arbiter_rr_pick.sv - combinational round-robin winner select
module rr_pick
    import mem_arb_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic [1:0]      ptr,
    output logic [1:0]      winner,
    output logic            valid
);

    logic [1:0] idx;

    // Scan from the farthest offset back to the pointer so the closest set bit wins.
    always_comb begin
        winner = 2'(REQ_FETCH);
        valid  = 1'b0;
        idx    = 2'd0;
        for (int off = NREQ - 1; off >= 0; off--) begin
            idx = 2'((int'(ptr) + off) % NREQ);
            if (req[idx]) begin
                winner = idx;
                valid  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin owner of the single-port memory
// Defining MEM_ARB_STATS_EN adds saturating per-requester grant counters on stat_grants.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW          = 16,
    parameter int DW          = 16,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      req_we,
    input  logic [NREQ*AW-1:0]   req_addr,
    input  logic [NREQ*DW-1:0]   req_wdata,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      done,
    output logic [DW-1:0]        rdata,
    output logic                 busy,
    output logic                 mem_en,
    output logic                 mem_we,
    output logic [AW-1:0]        mem_addr,
    output logic [DW-1:0]        mem_wdata,
    input  logic [DW-1:0]        mem_rdata
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [NREQ*STAT_W-1:0] stat_grants
`endif
);

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t        state_q, state_d;
    logic [1:0]    ptr_q, ptr_d;
    logic [1:0]    win_q, win_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          first_q, first_d;

    logic [1:0]    pick_w;
    logic          pick_valid;

    rr_pick u_rr_pick (
        .req    (req),
        .ptr    (ptr_q),
        .winner (pick_w),
        .valid  (pick_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= 2'd0;
            win_q   <= 2'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= 4'd0;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
            first_q <= first_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        win_d     = win_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        cnt_d     = cnt_q;
        first_d   = first_q;
        gnt       = '0;
        done      = '0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    win_d   = pick_w;
                    we_d    = req_we[pick_w];
                    addr_d  = req_addr[int'(pick_w)*AW +: AW];
                    wdata_d = req_wdata[int'(pick_w)*DW +: DW];
                    first_d = 1'b1;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (first_q) begin
                    gnt[win_q] = 1'b1;
                    mem_en     = 1'b1;
                    mem_we     = we_q;
                    mem_addr   = addr_q;
                    mem_wdata  = wdata_q;
                    cnt_d      = CNT_LOAD;
                    first_d    = 1'b0;
                end else if (cnt_q == 4'd0) begin
                    // Writes leave the last read value visible on rdata.
                    if (!we_q) begin
                        rdata_d = mem_rdata;
                    end
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                done[win_q] = 1'b1;
                ptr_d       = next_ptr(win_q);
                state_d     = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy  = (state_q != IDLE);
    assign rdata = rdata_q;

`ifdef MEM_ARB_STATS_EN
    logic [NREQ*STAT_W-1:0] stat_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_q <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (gnt[i] && (stat_q[i*STAT_W +: STAT_W] != '1)) begin
                    stat_q[i*STAT_W +: STAT_W] <= stat_q[i*STAT_W +: STAT_W] + STAT_W'(1);
                end
            end
        end
    end

    assign stat_grants = stat_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter (WAIT_CYCLES 1 and 4)
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst [2];
    logic [2:0]  req [2];
    logic [2:0]  req_we [2];
    logic [47:0] req_addr [2];
    logic [47:0] req_wdata [2];
    logic [2:0]  gnt [2];
    logic [2:0]  done [2];
    logic [15:0] rdata [2];
    logic        busy [2];
    logic        mem_en [2];
    logic        mem_we [2];
    logic [15:0] mem_addr [2];
    logic [15:0] mem_wdata [2];
    logic [15:0] mem_rdata [2];
`ifdef MEM_ARB_STATS_EN
    logic [47:0] stat [2];
`endif

    logic        pl_en = 1'b0;
    logic [7:0]  pl_addr = 8'd0;
    logic [15:0] pl_data = 16'd0;

    int n_tests = 0;
    int n_fail  = 0;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int WC = (g == 0) ? 1 : 4;
        logic [15:0] mem [256];
        int          since = 0;
        logic [7:0]  raddr = 8'd0;

        mem_port_arbiter #(.AW(16), .DW(16), .WAIT_CYCLES(WC)) u_dut (
            .clk         (clk),
            .reset       (rst[g]),
            .req         (req[g]),
            .req_we      (req_we[g]),
            .req_addr    (req_addr[g]),
            .req_wdata   (req_wdata[g]),
            .gnt         (gnt[g]),
            .done        (done[g]),
            .rdata       (rdata[g]),
            .busy        (busy[g]),
            .mem_en      (mem_en[g]),
            .mem_we      (mem_we[g]),
            .mem_addr    (mem_addr[g]),
            .mem_wdata   (mem_wdata[g]),
            .mem_rdata   (mem_rdata[g])
`ifdef MEM_ARB_STATS_EN
            ,
            .stat_grants (stat[g])
`endif
        );

        // Memory returns the word only in the exact cycle WC after the strobe.
        always @(posedge clk) begin
            if (pl_en) mem[pl_addr] <= pl_data;
            else if (mem_en[g] && mem_we[g]) mem[mem_addr[g][7:0]] <= mem_wdata[g];
            if (mem_en[g] && !mem_we[g]) begin
                since <= 1;
                raddr <= mem_addr[g][7:0];
            end else if (since != 0) begin
                since <= since + 1;
            end
        end
        assign mem_rdata[g] = (since == WC) ? mem[raddr] : 16'hDEAD;
    end

    typedef struct {
        int          idx;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [2:0]  exp_gnt;
        logic [15:0] exp_rd;
    } vec_t;

    function automatic int wc(input int d);
        return (d == 0) ? 1 : 4;
    endfunction

    function automatic int pick(input logic [2:0] r, input int p);
        for (int k = 0; k < 3; k++) if (r[(p + k) % 3]) return (p + k) % 3;
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic preload();
        logic [15:0] vals [4];
        vals = '{16'hABCD, 16'h1111, 16'h2222, 16'h3333};
        for (int i = 0; i < 4; i++) begin
            pl_en = 1'b1;
            pl_addr = 8'((i + 1) * 16);
            pl_data = vals[i];
            tick();
        end
        pl_en = 1'b0;
    endtask

    task automatic chk_quiet(input int d, input string nm);
        chk({nm, "_gnt"}, gnt[d], 0);
        chk({nm, "_done"}, done[d], 0);
        chk({nm, "_busy"}, busy[d], 0);
        chk({nm, "_mem_en"}, mem_en[d], 0);
        chk({nm, "_mem_we"}, mem_we[d], 0);
        chk({nm, "_mem_addr"}, mem_addr[d], 0);
        chk({nm, "_mem_wdata"}, mem_wdata[d], 0);
        chk({nm, "_rdata"}, rdata[d], 0);
    endtask

    task automatic reset_dut(input int d);
        rst[d] = 1'b1;
        req[d] = 3'b000;
        tick();
        chk_quiet(d, "reset");
        rst[d] = 1'b0;
    endtask

    task automatic single(input int d, input vec_t v, input string nm);
        req[d] = 3'b001 << v.idx;
        req_we[d][v.idx] = v.we;
        req_addr[d][v.idx*16 +: 16] = v.addr;
        req_wdata[d][v.idx*16 +: 16] = v.wdata;
        tick();
        chk({nm, "_gnt"}, gnt[d], v.exp_gnt);
        chk({nm, "_mem_en"}, mem_en[d], 1);
        chk({nm, "_mem_we"}, mem_we[d], v.we);
        chk({nm, "_mem_addr"}, mem_addr[d], v.addr);
        if (v.we) chk({nm, "_mem_wdata"}, mem_wdata[d], v.wdata);
        req[d] = 3'b000;
        for (int k = 1; k <= wc(d); k++) begin
            tick();
            chk({nm, "_early_done"}, done[d], 0);
            chk({nm, "_busy"}, busy[d], 1);
        end
        tick();
        chk({nm, "_done"}, done[d], v.exp_gnt);
        chk({nm, "_gnt_with_done"}, gnt[d], 0);
        chk({nm, "_rdata"}, rdata[d], v.exp_rd);
        chk({nm, "_busy_done"}, busy[d], 1);
        tick();
        chk({nm, "_busy_after"}, busy[d], 0);
    endtask

    task automatic wait_sig(input int d, input bit want_done, output logic [2:0] seen);
        seen = 3'b000;
        for (int k = 0; k < 30 && seen == 3'b000; k++) begin
            tick();
            seen = want_done ? done[d] : gnt[d];
        end
    endtask

    task automatic rand_run(input int d, input int ncyc);
        logic [15:0] addrs [4];
        logic [15:0] ref_mem [4];
        int          ai [3];
        int          ngr [3];
        int          ptr, w, due, pw;
        bit          pend, prev_idle, exp_busy;
        logic [2:0]  eg, ed, prev_req;
        logic [15:0] exp_rd, last_rd;
        addrs   = '{16'h0010, 16'h0020, 16'h0030, 16'h0040};
        ref_mem = '{16'hABCD, 16'h1111, 16'h2222, 16'h3333};
        ai = '{0, 0, 0};
        ngr = '{0, 0, 0};
        ptr = 0; w = 0; due = 0; pw = 0;
        pend = 1'b0; prev_idle = 1'b1; prev_req = 3'b000;
        exp_rd = 16'h0; last_rd = 16'h0;
        preload();
        reset_dut(d);
        for (int c = 0; c < ncyc; c++) begin
            tick();
            eg = 3'b000;
            if (prev_idle && prev_req != 3'b000) begin
                w  = pick(prev_req, ptr);
                eg = 3'b001 << w;
            end
            chk("rnd_gnt", gnt[d], eg);
            if (eg != 3'b000) begin
                chk("rnd_mem_en", mem_en[d], 1);
                chk("rnd_mem_addr", mem_addr[d], addrs[ai[w]]);
                chk("rnd_mem_we", mem_we[d], req_we[d][w]);
                if (req_we[d][w]) begin
                    chk("rnd_mem_wdata", mem_wdata[d], req_wdata[d][w*16 +: 16]);
                    ref_mem[ai[w]] = req_wdata[d][w*16 +: 16];
                    exp_rd = last_rd;
                end else begin
                    exp_rd = ref_mem[ai[w]];
                end
                last_rd = exp_rd;
                pend = 1'b1;
                pw   = w;
                due  = c + wc(d) + 1;
                ptr  = (w + 1) % 3;
                ngr[w]++;
                req[d][w] = 1'b0;
            end
            ed = (pend && c == due) ? (3'b001 << pw) : 3'b000;
            chk("rnd_done", done[d], ed);
            exp_busy = pend;
            chk("rnd_busy", busy[d], exp_busy);
            if (ed != 3'b000) begin
                chk("rnd_rdata", rdata[d], exp_rd);
                pend = 1'b0;
            end
            prev_idle = !exp_busy;
            for (int i = 0; i < 3; i++) begin
                if (!req[d][i] && !eg[i] && $urandom_range(0, 3) == 0) begin
                    ai[i] = int'($urandom_range(0, 3));
                    req_we[d][i] = 1'($urandom_range(0, 1));
                    req_addr[d][i*16 +: 16] = addrs[ai[i]];
                    req_wdata[d][i*16 +: 16] = 16'($urandom);
                    req[d][i] = 1'b1;
                end
            end
            prev_req = req[d];
        end
        req[d] = 3'b000;
`ifdef MEM_ARB_STATS_EN
        for (int i = 0; i < 3; i++) chk("rnd_stat", stat[d][i*16 +: 16], 64'(ngr[i]));
`endif
    endtask

    initial begin
        vec_t        tv [6];
        logic [2:0]  seen;
        logic [2:0]  order [4];

        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1;
            req[d] = 3'b000;
            req_we[d] = 3'b000;
            req_addr[d] = '0;
            req_wdata[d] = '0;
        end

        tv[0] = '{0, 1'b0, 16'h0010, 16'h0000, 3'b001, 16'hABCD};
        tv[1] = '{1, 1'b1, 16'h0020, 16'h5555, 3'b010, 16'hABCD};
        tv[2] = '{2, 1'b0, 16'h0020, 16'h0000, 3'b100, 16'h5555};
        tv[3] = '{2, 1'b1, 16'h0030, 16'h1234, 3'b100, 16'h5555};
        tv[4] = '{0, 1'b0, 16'h0030, 16'h0000, 3'b001, 16'h1234};
        tv[5] = '{1, 1'b0, 16'h0040, 16'h0000, 3'b010, 16'h3333};

        preload();
        reset_dut(0);
        reset_dut(1);

        for (int i = 0; i < 6; i++) single(0, tv[i], $sformatf("vec%0d", i));

        // Request raised and dropped while the port is busy is never granted.
        req[0] = 3'b001;
        req_we[0][0] = 1'b0;
        req_addr[0][15:0] = 16'h0010;
        tick();
        chk("wd_first_gnt", gnt[0], 3'b001);
        req[0] = 3'b100;
        tick();
        req[0] = 3'b000;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("wd_no_gnt", gnt[0], 0);
        end

        reset_dut(0);
        req[0] = 3'b111;
        req_we[0] = 3'b000;
        req_addr[0] = {16'h0030, 16'h0020, 16'h0010};
        order = '{3'b001, 3'b010, 3'b100, 3'b001};
        for (int n = 0; n < 4; n++) begin
            wait_sig(0, 1'b0, seen);
            chk("fair_gnt", seen, order[n]);
            if (n == 3) req[0] = 3'b000;
            wait_sig(0, 1'b1, seen);
            chk("fair_done", seen, order[n]);
        end
        tick();
        tick();

        single(1, '{0, 1'b0, 16'h0010, 16'h0000, 3'b001, 16'hABCD}, "lat4");

        req[1] = 3'b100;
        req_we[1][2] = 1'b0;
        req_addr[1][47:32] = 16'h0030;
        tick();
        chk("rstmid_gnt", gnt[1], 3'b100);
        req[1] = 3'b000;
        tick();
        rst[1] = 1'b1;
        tick();
        rst[1] = 1'b0;
        chk_quiet(1, "rstmid");
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("rstmid_no_done", done[1], 0);
        end
        req[1] = 3'b111;
        tick();
        chk("rstmid_ptr0", gnt[1], 3'b001);
        req[1] = 3'b000;
        wait_sig(1, 1'b1, seen);
        chk("rstmid_done", seen, 3'b001);
        tick();

        rand_run(0, 2000);
        rand_run(1, 2000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
